// File: rtl/hilo_ctrl_pkg.sv
// Shared encodings and defaults for the HI/LO sequencer and its register.
package hilo_ctrl_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned HILO_W          = 2 * XLEN;
  localparam int unsigned MUL_LAT_DEF     = 2;
  localparam int unsigned DIV_TIMEOUT_DEF = 40;
  localparam int unsigned MUL_CNT_W       = 3;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_HOLD     = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_reg.sv
// 64-bit HI/LO register with independent half write enables.
module hilo_reg
  import hilo_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [HILO_W-1:0] wr_data,
  output logic [HILO_W-1:0] hilo
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo <= '0;
    end else begin
      if (hi_we) hilo[HILO_W-1:XLEN] <= wr_data[HILO_W-1:XLEN];
      if (lo_we) hilo[XLEN-1:0]      <= wr_data[XLEN-1:0];
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage sequencer for multiply/divide/move-to-HI/LO; owns the HI/LO pair
// and stalls the pipeline while an arithmetic unit is working.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT     = MUL_LAT_DEF,
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic              stallE,
  input  logic              flushE,
  output logic              mul_start,
  output logic              mul_signed,
  input  logic [HILO_W-1:0] mul_result,
  output logic              div_start,
  output logic              div_annul,
  output logic              div_signed,
  output logic [XLEN-1:0]   div_opa,
  output logic [XLEN-1:0]   div_opb,
  input  logic              div_ready,
  input  logic [HILO_W-1:0] div_result,
  output logic              busy_stall,
  output logic [HILO_W-1:0] hilo,
  output logic              err
);

  localparam int unsigned DIV_CNT_W = $clog2(DIV_TIMEOUT + 1);

  state_e                 state;
  logic [MUL_CNT_W-1:0]   mul_cnt;
  logic [DIV_CNT_W-1:0]   div_cnt;
  logic [HILO_W-1:0]      res_q;

  logic                   accept;
  logic                   is_mul;
  logic                   is_div;
  logic                   commit;
  logic                   hi_we;
  logic                   lo_we;
  logic [HILO_W-1:0]      wr_data;

  // Accept decode, launch pulse for the multiplier, stall request and HI/LO write port.
  always_comb begin
    accept     = (state == S_IDLE) && op_valid && !stallE && !flushE;
    is_mul     = (op_code == OP_MULT) || (op_code == OP_MULTU);
    is_div     = (op_code == OP_DIV)  || (op_code == OP_DIVU);
    mul_start  = accept && is_mul;
    mul_signed = mul_start && (op_code == OP_MULT);
    commit     = (state == S_HOLD) && !stallE && !flushE;
    // The commit cycle already releases the pipeline.
    busy_stall = (accept && (is_mul || is_div)) ||
                 (state == S_MUL_WAIT) || (state == S_DIV_WAIT) ||
                 ((state == S_HOLD) && stallE);
    hi_we      = commit || (accept && (op_code == OP_MTHI));
    lo_we      = commit || (accept && (op_code == OP_MTLO));
    wr_data    = commit ? res_q : {src_a, src_a};
  end

  // Sequencer, latency/timeout counters, divider launch registers and result buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mul_cnt    <= '0;
      div_cnt    <= '0;
      res_q      <= '0;
      div_start  <= 1'b0;
      div_annul  <= 1'b0;
      div_signed <= 1'b0;
      div_opa    <= '0;
      div_opb    <= '0;
      err        <= 1'b0;
    end else begin
      div_start <= 1'b0;
      div_annul <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            mul_cnt <= MUL_CNT_W'(MUL_LAT);
            state   <= S_MUL_WAIT;
          end else if (accept && is_div) begin
            div_opa    <= src_a;
            div_opb    <= src_b;
            div_signed <= (op_code == OP_DIV);
            div_start  <= 1'b1;
            div_cnt    <= '0;
            state      <= S_DIV_WAIT;
          end
        end
        S_MUL_WAIT: begin
          if (flushE) begin
            state <= S_IDLE;
          end else begin
            mul_cnt <= mul_cnt - MUL_CNT_W'(1);
            // Counter reaches zero at this edge: product is valid now.
            if (mul_cnt == MUL_CNT_W'(1)) begin
              res_q <= mul_result;
              state <= S_HOLD;
            end
          end
        end
        S_DIV_WAIT: begin
          if (flushE) begin
            div_annul <= 1'b1;
            state     <= S_IDLE;
          end else if (div_ready) begin
            res_q <= div_result;
            state <= S_HOLD;
          end else if (div_cnt == DIV_CNT_W'(DIV_TIMEOUT - 1)) begin
            div_annul <= 1'b1;
            err       <= 1'b1;
            state     <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (flushE || !stallE) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  hilo_reg u_hilo_reg (
    .clk     (clk),
    .rst     (rst),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wr_data (wr_data),
    .hilo    (hilo)
  );

endmodule
